ah_snoop_fifo_admit_arb: RTL and testbench
==========================================

# ah_snoop_fifo_admit_arb

Admission controller and round-robin arbiter in front of the snoopable FIFO. It shares the FIFO write port between NUM_REQ requesters. Before enqueueing, it snoops each granted entry against the FIFO contents and drops duplicates, so that at most one copy of a value is pending. It is the only writer of the FIFO. The FIFO read side is not touched by this block.

## Interface
Parameters:
- DATA_W, 10, entry width; matches FIFO wdata/sdata width
- NUM_REQ, 4, number of requesters (2..8)
- DEDUP_EN, 1, 1 = drop entries that hit on snoop; 0 = snoop is skipped and every entry is pushed
- CNT_W, 16, width of the saturating statistics counters

Ports:
- clk  in  1  clock; all logic on the rising edge
- rstn  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester request
- req_data  in  NUM_REQ*DATA_W  request i occupies bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  one-hot accept strobe
- rsp_valid  out  NUM_REQ  one-hot completion pulse to the original requester
- rsp_dup  out  1  qualifies rsp_valid; 1 = entry dropped as a duplicate
- fifo_wdata  out  DATA_W  FIFO write data
- fifo_wvalid  out  1  FIFO write valid
- fifo_wready  in  1  FIFO write ready (not full)
- fifo_sdata  out  DATA_W  snoop compare value
- fifo_svalid  out  1  snoop request
- fifo_smatch  in  1  snoop result; valid the cycle after fifo_svalid
- busy  out  1  high in any state other than IDLE
- dup_cnt  out  CNT_W  number of dropped duplicates, saturating
- push_cnt  out  CNT_W  number of entries pushed, saturating

## Operation
- FSM states: IDLE, SNOOP, CHECK, PUSH, RESP. A one-hot encoding is allowed.
- IDLE:
  - If any req_valid is high, select the winner by round-robin: the first valid index at or after rr_ptr, wrapping modulo NUM_REQ.
  - Assert req_ready[winner] combinationally in the same cycle.
  - Latch req_data[winner] into a data register and winner into a grant register.
  - Set rr_ptr to (winner+1) mod NUM_REQ.
  - Go to SNOOP, or to PUSH if DEDUP_EN=0.
- SNOOP: fifo_svalid=1 and fifo_sdata=latched data for exactly one cycle, then go to CHECK.
- CHECK: sample fifo_smatch.
  - 1: set the dup flag, increment dup_cnt, go to RESP.
  - 0: go to PUSH.
- PUSH: fifo_wvalid=1 and fifo_wdata=latched data, held stable until fifo_wready=1. On the handshake cycle, increment push_cnt and go to RESP.
- RESP: rsp_valid[grant]=1 for one cycle, with rsp_dup=dup flag. Clear the dup flag and return to IDLE.
- req_ready is never asserted outside IDLE, so only one transaction is in flight at a time.
- Requesters hold req_valid and req_data stable until accepted. Deasserting early is legal; the request is simply not seen.
- Counters saturate at all-ones and do not wrap.
- The duplicate decision uses the FIFO contents at the snoop cycle. An entry popped by the FIFO reader between CHECK and RESP does not change the decision.
- When fifo_svalid=0 and fifo_wvalid=0, fifo_sdata and fifo_wdata are driven to 0.

## Timing
- Reset values: all outputs 0, rr_ptr=0, FSM=IDLE, counters=0. Reset asserted mid-transaction aborts it immediately:
  - no rsp_valid is issued;
  - fifo_wvalid drops asynchronously;
  - the requester re-requests after reset.
- Accept at cycle T, with DEDUP_EN=1:
  - fifo_svalid at T+1;
  - smatch sampled at T+2;
  - duplicate: rsp_valid at T+3;
  - non-duplicate with FIFO ready: push handshake at T+3, rsp_valid at T+4.
- Accept at cycle T, with DEDUP_EN=0: push at T+1 earliest, rsp_valid at T+2.
- FIFO full: the FSM waits in PUSH indefinitely with wvalid held high. No timeout.
- Back-to-back: the next accept is possible in the cycle after RESP. Peak throughput is one entry per 5 cycles (DEDUP_EN=1).
- Simultaneous requests: exactly one req_ready per accept. A continuously requesting agent waits at most NUM_REQ-1 grants.
- rr_ptr wrap: with winner=NUM_REQ-1, rr_ptr becomes 0.

## Test plan
- Reset, then req_valid[2]=1 with data 0x155 and smatch=0, wready=1:
  - req_ready[2] at T;
  - svalid with sdata=0x155 at T+1;
  - wvalid with wdata=0x155 at T+3;
  - rsp_valid=4'b0100 and rsp_dup=0 at T+4;
  - push_cnt=1.
- Same as above but smatch=1 at T+2: no wvalid; rsp_valid=4'b0100 and rsp_dup=1 at T+3; dup_cnt=1, push_cnt=0.
- All four req_valid held high with smatch=0: grant order is 0,1,2,3,0. Each requester gets exactly one rsp_valid per round.
- wready=0 for 10 cycles during PUSH: wvalid and wdata stay stable for all 10 cycles, no rsp_valid; one push after wready rises.
- Reset asserted in the CHECK state:
  - all outputs are 0 immediately;
  - after release, busy=0, rr_ptr=0, and the counters keep their reset value 0;
  - no stray rsp_valid.
- Counter saturation: with CNT_W=4 and 20 duplicate hits, dup_cnt=4'hF.

Source files
------------

// File: rtl/ah_snoop_fifo_admit_arb.sv
// Round-robin admission arbiter for the snoopable FIFO write port.
// Each granted entry is snooped against the FIFO contents and dropped if already pending.
module ah_snoop_fifo_admit_arb #(
   parameter int unsigned DATA_W   = 10,
   parameter int unsigned NUM_REQ  = 4,
   parameter bit          DEDUP_EN = 1'b1,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic                      rsp_dup,
   output logic [DATA_W-1:0]         fifo_wdata,
   output logic                      fifo_wvalid,
   input  logic                      fifo_wready,
   output logic [DATA_W-1:0]         fifo_sdata,
   output logic                      fifo_svalid,
   input  logic                      fifo_smatch,
   output logic                      busy,
   output logic [CNT_W-1:0]          dup_cnt,
   output logic [CNT_W-1:0]          push_cnt
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [2:0] {IDLE, SNOOP, CHECK, PUSH, RESP} state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   rr_ptr, grant_q, win_idx, cand, rr_next;
   logic               win_found;
   logic [DATA_W-1:0]  data_q;
   logic               dup_q;
   logic               accept;

   // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = PTR_W'((32'(rr_ptr) + i) % NUM_REQ);
         if (!win_found && req_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
      rr_next = (32'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
   end

   always_comb begin
      state_d   = state_q;
      req_ready = '0;
      accept    = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_found && rstn) begin
               req_ready[win_idx] = 1'b1;
               accept             = 1'b1;
               state_d            = DEDUP_EN ? SNOOP : PUSH;
            end
         end
         SNOOP:   state_d = CHECK;
         CHECK:   state_d = fifo_smatch ? RESP : PUSH;
         PUSH:    if (fifo_wready) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy        = (state_q != IDLE);
      fifo_svalid = (state_q == SNOOP);
      fifo_sdata  = fifo_svalid ? data_q : '0;
      fifo_wvalid = (state_q == PUSH);
      fifo_wdata  = fifo_wvalid ? data_q : '0;
      rsp_valid   = (state_q == RESP) ? (NUM_REQ'(1) << grant_q) : '0;
      rsp_dup     = (state_q == RESP) && dup_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         rr_ptr   <= '0;
         grant_q  <= '0;
         data_q   <= '0;
         dup_q    <= 1'b0;
         dup_cnt  <= '0;
         push_cnt <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            data_q  <= req_data[win_idx*DATA_W +: DATA_W];
            grant_q <= win_idx;
            rr_ptr  <= rr_next;
         end
         if (state_q == CHECK && fifo_smatch) begin
            dup_q <= 1'b1;
            if (dup_cnt != '1) dup_cnt <= dup_cnt + 1'b1;
         end
         if (state_q == PUSH && fifo_wready && push_cnt != '1)
            push_cnt <= push_cnt + 1'b1;
         if (state_q == RESP)
            dup_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ah_snoop_fifo_admit_arb.sv
// Directed bench for ah_snoop_fifo_admit_arb: one dedup instance, one pass-through instance.
module tb_ah_snoop_fifo_admit_arb;

   logic        clk;
   logic        rstn;
   logic [3:0]  req_valid;
   logic [39:0] req_data;
   logic        fifo_wready;
   logic        fifo_smatch;

   logic [3:0]  req_ready, rsp_valid, nd_req_ready, nd_rsp_valid;
   logic        rsp_dup, fifo_wvalid, fifo_svalid, busy;
   logic        nd_rsp_dup, nd_wvalid, nd_svalid, nd_busy;
   logic [9:0]  fifo_wdata, fifo_sdata, nd_wdata, nd_sdata;
   logic [3:0]  dup_cnt, push_cnt, nd_dup_cnt, nd_push_cnt;

   int checks = 0;
   int errors = 0;

   ah_snoop_fifo_admit_arb #(.DATA_W(10), .NUM_REQ(4), .DEDUP_EN(1'b1), .CNT_W(4)) u_dut (
      .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_dup(rsp_dup),
      .fifo_wdata(fifo_wdata), .fifo_wvalid(fifo_wvalid), .fifo_wready(fifo_wready),
      .fifo_sdata(fifo_sdata), .fifo_svalid(fifo_svalid), .fifo_smatch(fifo_smatch),
      .busy(busy), .dup_cnt(dup_cnt), .push_cnt(push_cnt));

   ah_snoop_fifo_admit_arb #(.DATA_W(10), .NUM_REQ(4), .DEDUP_EN(1'b0), .CNT_W(4)) u_nd (
      .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
      .req_ready(nd_req_ready), .rsp_valid(nd_rsp_valid), .rsp_dup(nd_rsp_dup),
      .fifo_wdata(nd_wdata), .fifo_wvalid(nd_wvalid), .fifo_wready(fifo_wready),
      .fifo_sdata(nd_sdata), .fifo_svalid(nd_svalid), .fifo_smatch(fifo_smatch),
      .busy(nd_busy), .dup_cnt(nd_dup_cnt), .push_cnt(nd_push_cnt));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic do_reset();
      req_valid = '0; req_data = '0; fifo_wready = 1'b1; fifo_smatch = 1'b0;
      @(negedge clk); rstn = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      req_valid = '0; req_data = '0; fifo_wready = 1'b1; fifo_smatch = 1'b0;
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++; if ({req_ready, rsp_valid, rsp_dup, fifo_wvalid, fifo_svalid, busy} !== 12'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected 000", {req_ready, rsp_valid, rsp_dup, fifo_wvalid, fifo_svalid, busy}); end
      checks++; if ({fifo_wdata, fifo_sdata, dup_cnt, push_cnt} !== 28'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", {fifo_wdata, fifo_sdata, dup_cnt, push_cnt}); end
      @(negedge clk); rstn = 1'b1;
      @(negedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
   endtask

   task automatic test_push();
      do_reset();
      req_data[2*10 +: 10] = 10'h155; req_valid = 4'b0100; #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL push_ready: got %b expected 0100", req_ready); end
      checks++; if (nd_req_ready !== 4'b0100) begin errors++; $display("FAIL nd_ready: got %b expected 0100", nd_req_ready); end
      @(negedge clk); req_valid = '0; #1;
      checks++; if ({fifo_svalid, fifo_sdata} !== {1'b1, 10'h155}) begin errors++; $display("FAIL push_snoop: got %b/%h expected 1/155", fifo_svalid, fifo_sdata); end
      checks++; if ({nd_wvalid, nd_wdata, nd_svalid} !== {1'b1, 10'h155, 1'b0}) begin errors++; $display("FAIL nd_push: got %b/%h/%b expected 1/155/0", nd_wvalid, nd_wdata, nd_svalid); end
      @(negedge clk); #1;
      checks++; if ({fifo_svalid, fifo_wvalid, fifo_sdata} !== 12'h0) begin errors++; $display("FAIL push_check: got %b/%b/%h expected 0/0/000", fifo_svalid, fifo_wvalid, fifo_sdata); end
      checks++; if ({nd_rsp_valid, nd_rsp_dup} !== 5'b01000) begin errors++; $display("FAIL nd_rsp: got %b/%b expected 0100/0", nd_rsp_valid, nd_rsp_dup); end
      @(negedge clk); #1;
      checks++; if ({fifo_wvalid, fifo_wdata, rsp_valid} !== {1'b1, 10'h155, 4'b0000}) begin errors++; $display("FAIL push_write: got %b/%h/%b expected 1/155/0000", fifo_wvalid, fifo_wdata, rsp_valid); end
      checks++; if ({nd_push_cnt, nd_busy} !== 5'b00010) begin errors++; $display("FAIL nd_cnt: got %h/%b expected 1/0", nd_push_cnt, nd_busy); end
      @(negedge clk); #1;
      checks++; if ({rsp_valid, rsp_dup, fifo_wvalid, fifo_wdata} !== {4'b0100, 1'b0, 1'b0, 10'h0}) begin errors++; $display("FAIL push_rsp: got %b/%b/%b/%h expected 0100/0/0/000", rsp_valid, rsp_dup, fifo_wvalid, fifo_wdata); end
      checks++; if ({push_cnt, dup_cnt} !== 8'h10) begin errors++; $display("FAIL push_cnt: got %h/%h expected 1/0", push_cnt, dup_cnt); end
      @(negedge clk); #1;
      checks++; if ({busy, rsp_valid} !== 5'b0) begin errors++; $display("FAIL push_idle: got %b/%b expected 0/0000", busy, rsp_valid); end
   endtask

   task automatic test_dup();
      do_reset();
      fifo_smatch = 1'b1;
      req_data[2*10 +: 10] = 10'h155; req_valid = 4'b0100; #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL dup_ready: got %b expected 0100", req_ready); end
      @(negedge clk); req_valid = '0; #1;
      checks++; if ({fifo_svalid, fifo_sdata} !== {1'b1, 10'h155}) begin errors++; $display("FAIL dup_snoop: got %b/%h expected 1/155", fifo_svalid, fifo_sdata); end
      @(negedge clk); #1;
      checks++; if (fifo_wvalid !== 1'b0) begin errors++; $display("FAIL dup_nowrite: got %b expected 0", fifo_wvalid); end
      @(negedge clk); #1;
      checks++; if ({rsp_valid, rsp_dup, fifo_wvalid} !== 6'b010010) begin errors++; $display("FAIL dup_rsp: got %b/%b/%b expected 0100/1/0", rsp_valid, rsp_dup, fifo_wvalid); end
      checks++; if ({dup_cnt, push_cnt} !== 8'h10) begin errors++; $display("FAIL dup_cnt: got %h/%h expected 1/0", dup_cnt, push_cnt); end
      @(negedge clk); #1;
      checks++; if ({busy, rsp_valid, rsp_dup} !== 6'b0) begin errors++; $display("FAIL dup_clear: got %b/%b/%b expected 0/0000/0", busy, rsp_valid, rsp_dup); end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_oh;
      int         k;
      do_reset();
      for (int unsigned i = 0; i < 4; i++) req_data[i*10 +: 10] = 10'(10'h100 + i);
      req_valid = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         exp_oh = 4'b0001 << (g % 4);
         #1;
         k = 0;
         while (req_ready == 4'b0000 && k < 12) begin @(negedge clk); #1; k++; end
         checks++; if (req_ready !== exp_oh) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", g, req_ready, exp_oh); end
         @(negedge clk); #1;
         k = 0;
         while (rsp_valid == 4'b0000 && k < 12) begin @(negedge clk); #1; k++; end
         checks++; if ({rsp_valid, rsp_dup} !== {exp_oh, 1'b0}) begin errors++; $display("FAIL rr_rsp%0d: got %b/%b expected %b/0", g, rsp_valid, rsp_dup, exp_oh); end
         @(negedge clk);
      end
      req_valid = '0;
      checks++; if (push_cnt !== 4'd5) begin errors++; $display("FAIL rr_push_cnt: got %0d expected 5", push_cnt); end
   endtask

   task automatic test_stall();
      int bad;
      do_reset();
      fifo_wready = 1'b0;
      req_data[1*10 +: 10] = 10'h2AA; req_valid = 4'b0010; #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL stall_ready: got %b expected 0010", req_ready); end
      @(negedge clk); req_valid = '0;
      repeat (2) @(negedge clk);
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         #1;
         checks++; if ({fifo_wvalid, fifo_wdata, rsp_valid} !== {1'b1, 10'h2AA, 4'b0000}) begin errors++; bad++; if (bad < 3) $display("FAIL stall_hold%0d: got %b/%h/%b expected 1/2aa/0000", c, fifo_wvalid, fifo_wdata, rsp_valid); end
         @(negedge clk);
      end
      fifo_wready = 1'b1; #1;
      checks++; if (push_cnt !== 4'd0) begin errors++; $display("FAIL stall_cnt_pre: got %0d expected 0", push_cnt); end
      @(negedge clk); #1;
      checks++; if ({rsp_valid, rsp_dup, fifo_wvalid, push_cnt} !== {4'b0010, 1'b0, 1'b0, 4'd1}) begin errors++; $display("FAIL stall_rsp: got %b/%b/%b/%0d expected 0010/0/0/1", rsp_valid, rsp_dup, fifo_wvalid, push_cnt); end
   endtask

   task automatic test_reset_mid();
      int bad;
      do_reset();
      req_data[1*10 +: 10] = 10'h0F0; req_valid = 4'b0010; #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_ready: got %b expected 0010", req_ready); end
      @(negedge clk); req_valid = '0;
      @(negedge clk); #1;
      checks++; if ({busy, fifo_svalid, fifo_wvalid} !== 3'b100) begin errors++; $display("FAIL mid_in_check: got %b/%b/%b expected 1/0/0", busy, fifo_svalid, fifo_wvalid); end
      rstn = 1'b0; #1;
      checks++; if ({req_ready, rsp_valid, rsp_dup, fifo_wvalid, fifo_svalid, busy, fifo_wdata, fifo_sdata, dup_cnt, push_cnt} !== 40'h0) begin errors++; $display("FAIL mid_outputs: got %h expected 0", {req_ready, rsp_valid, rsp_dup, fifo_wvalid, fifo_svalid, busy, fifo_wdata, fifo_sdata, dup_cnt, push_cnt}); end
      @(negedge clk); rstn = 1'b1;
      bad = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); #1;
         if ({busy, rsp_valid, fifo_wvalid, dup_cnt, push_cnt} !== 14'h0) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL mid_after: got %0d bad cycles expected 0", bad); end
      req_valid = 4'b1111; #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_rr_ptr: got %b expected 0001", req_ready); end
      @(negedge clk); req_valid = '0;
   endtask

   task automatic test_saturation();
      int k;
      do_reset();
      fifo_smatch = 1'b1;
      req_data[9:0] = 10'h3C3;
      for (int t = 0; t < 20; t++) begin
         req_valid = 4'b0001; #1;
         k = 0;
         while (req_ready != 4'b0001 && k < 12) begin @(negedge clk); #1; k++; end
         @(negedge clk); req_valid = '0; #1;
         k = 0;
         while (rsp_valid == 4'b0000 && k < 12) begin @(negedge clk); #1; k++; end
         if (t == 14) begin
            checks++; if (dup_cnt !== 4'hF) begin errors++; $display("FAIL sat_at15: got %h expected f", dup_cnt); end
         end
         @(negedge clk);
      end
      #1;
      checks++; if ({dup_cnt, push_cnt} !== 8'hF0) begin errors++; $display("FAIL sat_final: got %h/%h expected f/0", dup_cnt, push_cnt); end
   endtask

   initial begin
      rstn = 1'b0;
      test_reset();
      test_push();
      test_dup();
      test_round_robin();
      test_stall();
      test_reset_mid();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
